// File: rtl/fadd_arbiter.sv
// Round-robin arbiter that shares one multi-cycle fadd unit between NREQ
// requesters. One operation is in flight at a time: accept in IDLE, pulse
// start in ISSUE, wait for the unit (guarded by a watchdog) in WAIT, and hold
// the one-hot response in RESP until the granted requester takes it.
module fadd_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    input  logic [NREQ-1:0]      req_sub,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_y,
    output logic                 resp_err,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          fu_x1,
    output logic [31:0]          fu_x2,
    output logic                 fu_ready,
    input  logic                 fu_valid,
    input  logic [31:0]          fu_y,
    output logic [CNTW-1:0]      op_count,
    output logic                 timeout_flag
);

    localparam int IDXW = $clog2(NREQ);
    localparam int WDW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0]  WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);
    // Quiet NaN returned when the unit never answers.
    localparam logic [31:0]     QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   tag_q, tag_d;
    logic [31:0]       op_x1_q, op_x1_d;
    logic [31:0]       op_x2_q, op_x2_d;
    logic              op_sub_q, op_sub_d;
    logic [31:0]       res_q, res_d;
    logic              err_q, err_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              tflag_q, tflag_d;

    logic              grant_vld;
    logic [IDXW-1:0]   grant_idx;

    // Round-robin scan: first pending requester at or after ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise an
        // unassigned path would infer a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IDXW'(idx);
            end
        end
    end

    // Next-state logic for the FSM, operand/result capture, watchdog and counter.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tag_d     = tag_q;
        op_x1_d   = op_x1_q;
        op_x2_d   = op_x2_q;
        op_sub_d  = op_sub_q;
        res_d     = res_q;
        err_d     = err_q;
        wd_d      = wd_q;
        cnt_d     = cnt_q;
        tflag_d   = tflag_q;
        req_ready = '0;

        case (state_q)
            S_IDLE: begin
                // No handshake may complete while reset is held.
                if (rstn && grant_vld) begin
                    req_ready[grant_idx] = 1'b1;
                    op_x1_d  = req_x1[32*grant_idx +: 32];
                    op_x2_d  = req_x2[32*grant_idx +: 32];
                    op_sub_d = req_sub[grant_idx];
                    tag_d    = grant_idx;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A real result beats the watchdog when both land together.
                if (fu_valid) begin
                    res_d   = fu_y;
                    err_d   = 1'b0;
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    res_d   = QNAN;
                    err_d   = 1'b1;
                    tflag_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready[tag_q]) begin
                    ptr_d   = (tag_q == IDX_LAST) ? '0 : tag_q + IDXW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rstn) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            tag_q    <= '0;
            op_x1_q  <= '0;
            op_x2_q  <= '0;
            op_sub_q <= 1'b0;
            res_q    <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
            cnt_q    <= '0;
            tflag_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            tag_q    <= tag_d;
            op_x1_q  <= op_x1_d;
            op_x2_q  <= op_x2_d;
            op_sub_q <= op_sub_d;
            res_q    <= res_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
            cnt_q    <= cnt_d;
            tflag_q  <= tflag_d;
        end
    end

    // One-hot response valid for the granted requester while in RESP.
    always_comb begin
        resp_valid = '0;
        if (state_q == S_RESP) resp_valid[tag_q] = 1'b1;
    end

    // Operands come straight from registers so they stay put for the whole op;
    // subtraction is folded in by flipping the sign of operand B.
    assign fu_x1        = op_x1_q;
    assign fu_x2        = {op_x2_q[31] ^ op_sub_q, op_x2_q[30:0]};
    assign fu_ready     = (state_q == S_ISSUE);
    assign resp_y       = res_q;
    assign resp_err     = err_q;
    assign op_count     = cnt_q;
    assign timeout_flag = tflag_q;

endmodule
